// File: rtl/dmem_access_ctrl_pkg.sv
// Shared constants and types for the MEM-stage data-memory access controller.
// FSM encodings, mem_op decodes and error codes used by the future exception unit.
package dmem_access_ctrl_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [1:0] MemNone = 2'b00;
    localparam logic [1:0] MemWr   = 2'b01;
    localparam logic [1:0] MemRd   = 2'b10;
    localparam logic [1:0] MemIll  = 2'b11;

    typedef enum logic [1:0] {
        ErrNone     = 2'd0,
        ErrMisalign = 2'd1,
        ErrIllegal  = 2'd2,
        ErrTimeout  = 2'd3
    } dmem_err_e;

    function automatic logic is_access(input logic [1:0] op);
        return (op == MemWr) || (op == MemRd);
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_timeout_ctr.sv
// Clear/enable saturating counter; expired_o flags the enabled cycle that brings the
// count up to TIMEOUT.
module dmem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign expired_o = en_i && (cnt_q >= CntLast);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer for a variable-latency req/ack data memory: freezes the
// pipeline while an access is outstanding, returns load data and flags errors.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [1:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              stall_pipe_o,
    output logic [DATA_W-1:0] rdata_out_o,
    output logic              rdata_valid_o,
    output logic              err_misalign_o,
    output logic              err_illegal_o,
    output logic              err_timeout_o
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              mis_q, mis_d;
    logic              ill_q, ill_d;
    logic              tmo_q, tmo_d;

    logic      access_ok;
    dmem_err_e idle_err;
    logic      cnt_clr, cnt_en, cnt_expired;

    dmem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (cnt_expired)
    );

    // Illegal encoding wins over misalignment.
    always_comb begin
        access_ok = is_access(mem_op_i) && (mem_addr_i[1:0] == 2'b00);
        idle_err  = ErrNone;
        if (mem_op_i == MemIll) begin
            idle_err = ErrIllegal;
        end else if (is_access(mem_op_i) && (mem_addr_i[1:0] != 2'b00)) begin
            idle_err = ErrMisalign;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        req_d    = 1'b0;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        mis_d    = 1'b0;
        ill_d    = 1'b0;
        tmo_d    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            StIdle: begin
                if (access_ok) begin
                    state_d = StWait;
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    we_d    = mem_op_i[0];
                    req_d   = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    ill_d = (idle_err == ErrIllegal);
                    mis_d = (idle_err == ErrMisalign);
                end
            end
            StWait: begin
                cnt_en = 1'b1;
                // Ack on the expiring cycle still counts as success.
                if (dmem_ack_i) begin
                    state_d = StResp;
                    if (!we_q) begin
                        rdata_d  = dmem_rdata_i;
                        rvalid_d = 1'b1;
                    end
                end else if (cnt_expired) begin
                    state_d = StResp;
                    tmo_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    req_d = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign stall_pipe_o = !reset_i &&
                          (((state_q == StIdle) && access_ok) || (state_q == StWait));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            req_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            mis_q    <= 1'b0;
            ill_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            req_q    <= req_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            mis_q    <= mis_d;
            ill_q    <= ill_d;
            tmo_q    <= tmo_d;
        end
    end

    assign dmem_req_o     = req_q;
    assign dmem_we_o      = we_q;
    assign dmem_addr_o    = addr_q;
    assign dmem_wdata_o   = wdata_q;
    assign rdata_out_o    = rdata_q;
    assign rdata_valid_o  = rvalid_q;
    assign err_misalign_o = mis_q;
    assign err_illegal_o  = ill_q;
    assign err_timeout_o  = tmo_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios then random transactions, each
// checked cycle by cycle against a transaction-level expectation.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    localparam int T = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_pipe;
    logic [31:0] rdata_out;
    logic        rdata_valid;
    logic        err_misalign;
    logic        err_illegal;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: last value handed to MEM/WB and error pulses owed next cycle.
    logic [31:0] model_rdata = '0;
    logic        pend_ill = 1'b0;
    logic        pend_mis = 1'b0;

    dmem_access_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (T)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .mem_op_i       (mem_op),
        .mem_addr_i     (mem_addr),
        .mem_wdata_i    (mem_wdata),
        .dmem_req_o     (dmem_req),
        .dmem_we_o      (dmem_we),
        .dmem_addr_o    (dmem_addr),
        .dmem_wdata_o   (dmem_wdata),
        .dmem_ack_i     (dmem_ack),
        .dmem_rdata_i   (dmem_rdata),
        .stall_pipe_o   (stall_pipe),
        .rdata_out_o    (rdata_out),
        .rdata_valid_o  (rdata_valid),
        .err_misalign_o (err_misalign),
        .err_illegal_o  (err_illegal),
        .err_timeout_o  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle and apply this cycle's inputs; outputs are settled on return.
    task automatic cyc(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic ack, input logic [31:0] rd);
        @(posedge clk);
        #1;
        mem_op     = op;
        mem_addr   = addr;
        mem_wdata  = wd;
        dmem_ack   = ack;
        dmem_rdata = rd;
        #1;
    endtask

    task automatic check_common(input logic exp_stall, input logic exp_req,
                                input logic exp_valid, input logic exp_tmo);
        chk("stall", stall_pipe, exp_stall);
        chk("req", dmem_req, exp_req);
        chk("rdata_valid", rdata_valid, exp_valid);
        chk("err_timeout", err_timeout, exp_tmo);
        chk("err_illegal", err_illegal, pend_ill);
        chk("err_misalign", err_misalign, pend_mis);
        chk("rdata_out", rdata_out, model_rdata);
        pend_ill = 1'b0;
        pend_mis = 1'b0;
    endtask

    // One EX/MEM instruction. dly = WAIT cycle carrying the ack; 0 = never acked,
    // T+1 = ack arrives one cycle too late (during the release cycle).
    task automatic access(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int dly, input logic [31:0] rd, input logic idle_ack);
        logic is_acc;
        logic tmo;
        int   n;
        is_acc = ((op == MemWr) || (op == MemRd)) && (addr[1:0] == 2'b00);
        cyc(op, addr, wd, idle_ack, $urandom);
        check_common(is_acc, 1'b0, 1'b0, 1'b0);
        pend_ill = (op == MemIll);
        pend_mis = ((op == MemWr) || (op == MemRd)) && (addr[1:0] != 2'b00);
        if (is_acc) begin
            tmo = !((dly >= 1) && (dly <= T));
            n   = tmo ? T : dly;
            for (int k = 1; k <= n; k++) begin
                cyc(op, addr, wd, (k == dly), (k == dly) ? rd : 32'($urandom));
                check_common(1'b1, 1'b1, 1'b0, 1'b0);
                chk("dmem_we", dmem_we, op[0]);
                chk("dmem_addr", dmem_addr, addr);
                chk("dmem_wdata", dmem_wdata, wd);
            end
            if (tmo) model_rdata = '0;
            else if (op == MemRd) model_rdata = rd;
            cyc(op, addr, wd, (dly == n + 1), $urandom);
            check_common(1'b0, 1'b0, (op == MemRd) && !tmo, tmo);
        end
    endtask

    task automatic reset_in_wait;
        cyc(MemRd, 32'h300, 32'h0, 1'b0, 32'h0);
        chk("rst_idle_stall", stall_pipe, 1'b1);
        cyc(MemRd, 32'h300, 32'h0, 1'b0, 32'h0);
        chk("rst_wait1_req", dmem_req, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mem_op = MemNone;
        #1;
        model_rdata = '0;
        pend_ill    = 1'b0;
        pend_mis    = 1'b0;
        check_common(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        chk("rst_addr", dmem_addr, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        mem_op     = MemNone;
        mem_addr   = '0;
        mem_wdata  = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_common(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_we", dmem_we, 1'b0);
        chk("reset_addr", dmem_addr, 32'h0);
        chk("reset_wdata", dmem_wdata, 32'h0);

        access(MemRd, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        access(MemWr, 32'h204, 32'h12345678, 1, 32'hAAAA5555, 1'b0);
        access(MemRd, 32'h400, 32'h0, 1, 32'hCAFEF00D, 1'b0);
        access(MemWr, 32'h404, 32'h0BADC0DE, 1, 32'h0, 1'b0);
        access(MemRd, 32'h103, 32'h0, 1, 32'h0, 1'b0);
        access(MemIll, 32'h108, 32'h0, 1, 32'h0, 1'b0);
        access(MemRd, 32'h500, 32'h0, T + 1, 32'h77777777, 1'b0);
        access(MemNone, 32'h0, 32'h0, 0, 32'h0, 1'b1);
        access(MemRd, 32'h504, 32'h0, T, 32'h13579BDF, 1'b0);
        reset_in_wait();
        access(MemRd, 32'h600, 32'h0, 2, 32'h2468ACE0, 1'b0);

        for (int i = 0; i < 250; i++) begin
            logic [1:0]  op;
            logic [31:0] addr;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) op = MemNone;
            else if (sel == 1) op = MemIll;
            else if (sel < 6) op = MemRd;
            else op = MemWr;
            addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            access(op, addr, $urandom, $urandom_range(0, T + 1), $urandom,
                   1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every data-memory access issued from the MEM stage of the 5-stage pipeline against a variable-latency req/ack data memory.
- Sits between the EX/MEM pipeline register outputs and the data memory port.
- Freezes the pipeline while an access is outstanding, returns load data, and flags misaligned, illegal and timed-out accesses.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data word width
- TIMEOUT, 15, maximum cycles spent waiting for dmem_ack before abort (1..255)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- mem_op  in  2  memory control from EX/MEM: bit1 = read, bit0 = write, 00 = no access
- mem_addr  in  ADDR_W  ALU result from EX/MEM, used as byte address
- mem_wdata  in  DATA_W  store data from EX/MEM
- dmem_req  out  1  access request to data memory
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req = 1
- dmem_addr  out  ADDR_W  latched address; valid while dmem_req = 1
- dmem_wdata  out  DATA_W  latched store data; valid while dmem_req = 1
- dmem_ack  in  1  one-cycle completion pulse from memory
- dmem_rdata  in  DATA_W  read data, valid with dmem_ack
- stall_pipe  out  1  holds PC, IF/ID, ID/EX and EX/MEM registers
- rdata_out  out  DATA_W  load data handed to MEM/WB
- rdata_valid  out  1  one-cycle pulse: rdata_out carries completed load data
- err_misalign  out  1  one-cycle pulse: mem_addr[1:0] != 0 on a new access
- err_illegal  out  1  one-cycle pulse: mem_op = 11
- err_timeout  out  1  one-cycle pulse: no ack within TIMEOUT cycles

Behaviour:
- Reset values: all outputs 0. FSM = IDLE, timeout counter = 0, latched address/data/we = 0. Reset overrides any state, including mid-WAIT; dmem_req is 0 from the cycle after the reset edge.
- States:
  - IDLE: accept a new access.
  - WAIT: request outstanding.
  - RESP: one-cycle release.
- IDLE, mem_op in {01, 10} and mem_addr[1:0] = 0:
  - stall_pipe = 1 (combinational) in this cycle.
  - At the edge: latch addr, wdata and we = mem_op[0]; clear counter; go to WAIT.
- IDLE, mem_op = 11: err_illegal pulses, no access, no stall, stay IDLE.
- IDLE, misaligned read/write: err_misalign pulses, no access, no stall, stay IDLE. The illegal check has priority over the misalign check.
- WAIT:
  - dmem_req = 1 and stall_pipe = 1; counter increments each cycle.
  - dmem_ack = 1: capture dmem_rdata if it was a read, then go to RESP. An ack in the same cycle the counter reaches TIMEOUT counts as success.
  - Counter reaches TIMEOUT with no ack: go to RESP with the timeout flag set.
- RESP:
  - stall_pipe = 0, so the pipeline advances at the end of this cycle.
  - Completed read: rdata_valid = 1 and rdata_out = captured data.
  - Timeout: err_timeout = 1 and rdata_out = 0.
  - mem_op in this cycle still describes the finished instruction and is ignored.
  - Always returns to IDLE.
- rdata_out holds its value until the next load completes or a timeout occurs.
- Minimum cost: 2 stall cycles per access (ack in the first WAIT cycle).
  - Cycle 0: IDLE, stall = 1.
  - Cycle 1: WAIT, req = 1, ack arrives.
  - Cycle 2: RESP, stall = 0.
- Outputs other than stall_pipe are registered; stall_pipe is a decode of state plus mem_op.
- dmem_ack outside WAIT is ignored. A late ack arriving after a timeout is dropped.
- Counter width: clog2(TIMEOUT+1). It saturates and never wraps.

Decomposition:
- Shared package (cpu_pkg):
  - state enum {IDLE, WAIT, RESP}
  - mem_op encoding constants MEM_NONE = 00, MEM_WR = 01, MEM_RD = 10
  - error-code constants reused by the future exception unit
- One natural sub-module, dmem_timeout_ctr: clear/enable saturating counter with an expired output, parameterised by TIMEOUT.

Test Plan:
- Load: mem_op = 10, addr = 0x100, ack in the 3rd WAIT cycle with rdata = 0xDEADBEEF.
  - stall high 4 cycles, req high 3 cycles, dmem_we = 0, dmem_addr = 0x100.
  - Then rdata_valid pulses once with rdata_out = 0xDEADBEEF, stall low.
- Store: mem_op = 01, addr = 0x204, wdata = 0x12345678, ack on the first WAIT cycle.
  - dmem_we = 1 with the latched data, stall exactly 2 cycles, no rdata_valid.
- Back-to-back: a load followed immediately by a store, both acked in 1 cycle.
  - Exactly two separate req bursts, no duplicate access during either RESP cycle.
- Errors:
  - addr = 0x103 with mem_op = 10: err_misalign 1 cycle, no req, no stall.
  - mem_op = 11: err_illegal only.
- Timeout: TIMEOUT = 4, no ack.
  - req high 4 cycles, then err_timeout pulses, rdata_out = 0, stall releases.
  - An ack injected afterwards is ignored.
- Reset in WAIT cycle 2: req, stall and all flags are 0 on the next cycle, FSM = IDLE, and a fresh load then completes normally.
